// File: rtl/bitplane_line_loader.sv
`default_nettype none
// ============================================================================
// Module   : bitplane_line_loader
// Brief    : Fetches a row pair from an RGB frame buffer, extracts one bit
//            plane and loads the back bank of a ping-pong line buffer.
// Revision : 1.0  initial release
// ============================================================================
module bitplane_line_loader #(
  parameter int k_width       = 64,
  parameter int k_height      = 64,
  parameter int k_color_bits  = 8,
  parameter int k_mem_latency = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic [$clog2(k_height/2)-1:0]       row_sel,
  input  logic [$clog2(k_color_bits)-1:0]     plane_sel,
  input  logic                                swap,
  output logic                                busy,
  output logic                                done,
  output logic                                mem_rd,
  output logic [$clog2(k_width*k_height)-1:0] mem_addr,
  input  logic [3*k_color_bits-1:0]           mem_rdata,
  input  logic [$clog2(k_width)-1:0]          rd_x,
  output logic [5:0]                          rd_data
);

  localparam int c_aw         = $clog2(k_width*k_height);
  localparam int c_cw         = $clog2(k_width);
  localparam int c_rw         = $clog2(k_height/2);
  localparam int c_pw         = $clog2(k_color_bits);
  localparam int c_dw         = $clog2(k_mem_latency+1);
  localparam int c_half_rows  = k_height/2;
  localparam int c_col_last   = k_width-1;
  localparam int c_drain_last = k_mem_latency-1;

  localparam logic [c_pw:0]   c_colors    = k_color_bits[c_pw:0];
  localparam logic [c_cw:0]   c_width_x   = k_width[c_cw:0];
  localparam logic [c_aw-1:0] c_half_addr = c_half_rows[c_aw-1:0];
  localparam logic [c_aw-1:0] c_width_a   = k_width[c_aw-1:0];

  typedef enum logic [1:0] {
    kIdle  = 2'd0,
    kFetch = 2'd1,
    kDrain = 2'd2,
    kDone  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [c_cw-1:0]   r_col;
  logic              r_half;
  logic [c_rw-1:0]   r_row;
  logic [c_pw-1:0]   r_plane;
  logic [c_dw-1:0]   r_drain;
  logic              r_front;
  logic              r_swap_pend;
  logic              w_toggle;
  logic [c_aw-1:0]   w_y;
  logic [c_aw-1:0]   w_addr;

  logic              r_tag_v    [k_mem_latency];
  logic [c_cw-1:0]   r_tag_col  [k_mem_latency];
  logic              r_tag_half [k_mem_latency];
  logic              w_ret;

  logic [k_color_bits-1:0] w_ch_r;
  logic [k_color_bits-1:0] w_ch_g;
  logic [k_color_bits-1:0] w_ch_b;
  logic [2:0]              w_bits;
  logic [2:0]              r_stage;
  logic [5:0]              r_bank [2][k_width];
  logic [5:0]              r_rd_data;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= kIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != kIdle);
    done         = 1'b0;
    mem_rd       = 1'b0;
    mem_addr     = '0;
    case (r_state)
      kIdle: begin
        if (start) w_state_next = kFetch;
      end
      kFetch: begin
        mem_rd   = 1'b1;
        mem_addr = w_addr;
        if (r_half && r_col == c_col_last[c_cw-1:0]) w_state_next = kDrain;
      end
      kDrain: begin
        if (r_drain == c_drain_last[c_dw-1:0]) w_state_next = kDone;
      end
      kDone: begin
        done         = 1'b1;
        w_state_next = kIdle;
      end
      default: w_state_next = kIdle;
    endcase
  end

  // ------------------------------------------------ load counters / address
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_col   <= '0;
      r_half  <= 1'b0;
      r_row   <= '0;
      r_plane <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        kIdle: begin
          if (start) begin
            r_col   <= '0;
            r_half  <= 1'b0;
            r_row   <= row_sel;
            r_plane <= plane_sel;
          end
        end
        kFetch: begin
          r_half  <= ~r_half;
          r_drain <= '0;
          if (r_half) r_col <= r_col + c_cw'(1);
        end
        kDrain:  r_drain <= r_drain + c_dw'(1);
        default: ;
      endcase
    end
  end

  assign w_y    = c_aw'(r_row) + (r_half ? c_half_addr : '0);
  assign w_addr = w_y * c_width_a + c_aw'(r_col);

  // ---------------------------------------------- bank select and swap
  // A swap seen while busy is held until the done cycle so the driver never
  // sees a half-loaded bank; done+swap in the same cycle still flips once.
  assign w_toggle = (r_state == kIdle && swap) ||
                    (r_state == kDone && (swap || r_swap_pend));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_front     <= 1'b0;
      r_swap_pend <= 1'b0;
    end else begin
      r_front <= r_front ^ w_toggle;
      if (r_state == kDone)
        r_swap_pend <= 1'b0;
      else if (r_state != kIdle && swap)
        r_swap_pend <= 1'b1;
    end
  end

  // ---------------------------------------------------- return pipeline
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < k_mem_latency; i++) begin
        r_tag_v[i]    <= 1'b0;
        r_tag_col[i]  <= '0;
        r_tag_half[i] <= 1'b0;
      end
    end else begin
      r_tag_v[0]    <= mem_rd;
      r_tag_col[0]  <= r_col;
      r_tag_half[0] <= r_half;
      for (int i = 1; i < k_mem_latency; i++) begin
        r_tag_v[i]    <= r_tag_v[i-1];
        r_tag_col[i]  <= r_tag_col[i-1];
        r_tag_half[i] <= r_tag_half[i-1];
      end
    end
  end

  assign w_ret  = r_tag_v[k_mem_latency-1];
  assign w_ch_r = mem_rdata[3*k_color_bits-1 -: k_color_bits];
  assign w_ch_g = mem_rdata[2*k_color_bits-1 -: k_color_bits];
  assign w_ch_b = mem_rdata[k_color_bits-1:0];

  always_comb begin
    w_bits = 3'b000;
    if ({1'b0, r_plane} < c_colors)
      w_bits = {w_ch_r[r_plane], w_ch_g[r_plane], w_ch_b[r_plane]};
  end

  // Top half waits in r_stage so each column is a single 6-bit write.
  always_ff @(posedge clock) begin
    if (w_ret && !r_tag_half[k_mem_latency-1])
      r_stage <= w_bits;
    if (w_ret && r_tag_half[k_mem_latency-1])
      r_bank[~r_front][r_tag_col[k_mem_latency-1]] <= {r_stage, w_bits};
  end

  // ---------------------------------------------------------- read port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_rd_data <= '0;
    else if ({1'b0, rd_x} < c_width_x)
      r_rd_data <= r_bank[r_front][rd_x];
    else
      r_rd_data <= '0;
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire
